// File: rtl/video_in_pkg.sv
// Shared constants and types for the video input packer and the store stage.
package video_in_pkg;

    localparam int p_WIDTH       = 640;  // pixels per line, multiple of 4
    localparam int p_HEIGHT      = 480;  // lines per frame
    localparam int NB_PACK_STORE = 16;   // words per store burst
    localparam int FIFO_DEPTH    = 64;   // words, power of 2
    localparam int PIX_CNT_W     = 20;   // pixel counter width

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,  // disarmed
        ST_WAIT_SOF = 2'd1,  // armed, waiting for frame_valid rise
        ST_CAPTURE  = 2'd2   // packing pixels of the current frame
    } pack_state_e;

    function automatic int frame_pixels(input int w, input int h);
        return w * h;
    endfunction

    localparam int PIX_PER_FRAME = frame_pixels(p_WIDTH, p_HEIGHT);

endpackage

// File: rtl/video_in_pack_if.sv
// Camera stream in, packed-word read port out.
interface video_in_pack_if;
    logic        new_addr;
    logic        frame_valid;
    logic        line_valid;
    logic [7:0]  pixel_in;
    logic        r_ack;
    logic [31:0] data_fifo;
    logic        nb_pack_available;
    logic        overflow;
    logic        short_frame;

    // Camera + store stage side
    modport master (
        output new_addr, frame_valid, line_valid, pixel_in, r_ack,
        input  data_fifo, nb_pack_available, overflow, short_frame
    );

    // Packer side
    modport slave (
        input  new_addr, frame_valid, line_valid, pixel_in, r_ack,
        output data_fifo, nb_pack_available, overflow, short_frame
    );
endinterface

// File: rtl/video_in_fifo.sv
// Synchronous show-ahead FIFO; head word reads as 0 while empty.
module video_in_fifo #(
    parameter int DEPTH = 64,
    parameter int DW    = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          nRST,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] wr_data,
    input  logic          pop,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer/count update; flush wins over any push or pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Pointer/count registers
    always_ff @(posedge clk) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed: pointers define validity
    always_ff @(posedge clk) begin
        if (nRST && do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/video_in_pack.sv
// Packs 4 camera pixels per 32-bit word into a FIFO, armed once per frame.
module video_in_pack #(
    parameter int p_WIDTH       = video_in_pkg::p_WIDTH,
    parameter int p_HEIGHT      = video_in_pkg::p_HEIGHT,
    parameter int NB_PACK_STORE = video_in_pkg::NB_PACK_STORE,
    parameter int FIFO_DEPTH    = video_in_pkg::FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           nRST,
    video_in_pack_if.slave bus
);
    import video_in_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PIX_CNT_W-1:0] FRAME_PIX = PIX_CNT_W'(frame_pixels(p_WIDTH, p_HEIGHT));

    pack_state_e          state_q, state_d;
    logic                 fv_prev_q;
    logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [1:0]           grp_q, grp_d;
    logic [23:0]          pack_q, pack_d;
    logic                 overflow_q, overflow_d;
    logic                 short_q, short_d;

    logic        sof, capturing, accept, last_pix, early_end;
    logic        push, pop_ok, full, empty;
    logic [AW:0] count;
    logic [31:0] rd_data;

    assign sof       = bus.frame_valid & ~fv_prev_q;
    // The frame-start cycle already counts as capture so a pixel coincident
    // with the frame_valid rise is not lost
    assign capturing = (state_q == ST_CAPTURE) | ((state_q == ST_WAIT_SOF) & sof);
    assign accept    = ~bus.new_addr & capturing & bus.frame_valid & bus.line_valid;
    assign last_pix  = accept & (pix_cnt_q == FRAME_PIX - 1'b1);
    assign early_end = ~bus.new_addr & (state_q == ST_CAPTURE) & ~bus.frame_valid;
    assign pop_ok    = bus.r_ack & ~empty;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!nRST) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; new_addr re-arms from anywhere
    always_comb begin
        state_d = state_q;
        if (bus.new_addr) state_d = ST_WAIT_SOF;
        else begin
            unique case (state_q)
                ST_WAIT_SOF: if (sof) state_d = ST_CAPTURE;
                ST_CAPTURE:  if (early_end || last_pix) state_d = ST_IDLE;
                default:     state_d = state_q;
            endcase
        end
    end

    // FSM outputs: a word leaves the packer on the 4th accepted pixel
    always_comb begin
        push = accept & (grp_q == 2'd3);
    end

    // Packer, pixel counter and sticky flags
    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        grp_d      = grp_q;
        pack_d     = pack_q;
        overflow_d = overflow_q;
        short_d    = short_q;
        if (bus.new_addr) begin
            pix_cnt_d  = '0;
            grp_d      = '0;
            pack_d     = '0;
            overflow_d = 1'b0;
            short_d    = 1'b0;
        end else begin
            if (accept) begin
                pix_cnt_d = pix_cnt_q + 1'b1;
                grp_d     = grp_q + 1'b1;
                case (grp_q)
                    2'd0:    pack_d[7:0]   = bus.pixel_in;
                    2'd1:    pack_d[15:8]  = bus.pixel_in;
                    2'd2:    pack_d[23:16] = bus.pixel_in;
                    default: pack_d        = pack_q;
                endcase
            end
            // Frame cut short: drop the partial group
            if (early_end) begin
                short_d = 1'b1;
                grp_d   = '0;
                pack_d  = '0;
            end
            if (push && full && !pop_ok) overflow_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!nRST) begin
            fv_prev_q  <= 1'b0;
            pix_cnt_q  <= '0;
            grp_q      <= '0;
            pack_q     <= '0;
            overflow_q <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            fv_prev_q  <= bus.frame_valid;
            pix_cnt_q  <= pix_cnt_d;
            grp_q      <= grp_d;
            pack_q     <= pack_d;
            overflow_q <= overflow_d;
            short_q    <= short_d;
        end
    end

    video_in_fifo #(.DEPTH(FIFO_DEPTH), .DW(32)) u_fifo (
        .clk     (clk),
        .nRST    (nRST),
        .flush   (bus.new_addr),
        .push    (push),
        .wr_data ({bus.pixel_in, pack_q}),
        .pop     (bus.r_ack),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign bus.data_fifo         = rd_data;
    assign bus.nb_pack_available = (count >= (AW+1)'(NB_PACK_STORE));
    assign bus.overflow          = overflow_q;
    assign bus.short_frame       = short_q;

endmodule

// File: tb/tb_video_in_pack.sv
// Directed bench for video_in_pack with a reduced 64x32 frame.
module tb_video_in_pack;
    import video_in_pkg::*;

    localparam int PW = 64;
    localparam int PH = 32;

    logic clk  = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // store-stage model state
    bit          auto_pop = 1'b0;
    logic        pop_ack = 1'b0;
    logic        man_ack = 1'b0;
    int          pop_left = 0;
    int          pop_cnt = 0;
    int          pop_base = 0;
    int          err_cnt = 0;
    logic [31:0] first_word = '0;
    logic [31:0] last_word;

    video_in_pack_if bus();

    assign bus.r_ack = pop_ack | man_ack;

    video_in_pack #(.p_WIDTH(PW), .p_HEIGHT(PH), .NB_PACK_STORE(16), .FIFO_DEPTH(64)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ramp_word(input int j);
        int p;
        p = 4 * j;
        return {8'(p + 3), 8'(p + 2), 8'(p + 1), 8'(p)};
    endfunction

    // Store model: bursts of 16 pops whenever a pack is available
    always @(negedge clk) begin
        if (pop_left == 0 && auto_pop && bus.nb_pack_available) pop_left = 16;
        if (pop_left > 0) begin
            if (pop_cnt == pop_base) first_word = bus.data_fifo;
            if (bus.data_fifo !== ramp_word(pop_cnt - pop_base)) err_cnt++;
            pop_cnt++;
            pop_left--;
            pop_ack = 1'b1;
        end else begin
            pop_ack = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.line_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pix(input logic [7:0] v);
        bus.line_valid = 1'b1;
        bus.pixel_in   = v;
        @(negedge clk);
    endtask

    task automatic arm();
        bus.new_addr = 1'b1;
        @(negedge clk);
        bus.new_addr = 1'b0;
    endtask

    // Ramp frame; optional new_addr / r_ack injected alongside pixel index
    task automatic frame(input int npix, input int na_at, input int ack_at, input int mode);
        bus.frame_valid = 1'b1;
        idle(2);
        for (int i = 0; i < npix; i++) begin
            if (i > 0 && (i % PW) == 0) idle(3);
            bus.new_addr = (i == na_at);
            man_ack      = (i == ack_at);
            pix(8'(i));
            bus.new_addr = 1'b0;
            man_ack      = 1'b0;
            if (mode == 1) begin
                if (i == 59)  check("nb_at_15_words", 32'(bus.nb_pack_available), 32'd0);
                if (i == 63)  check("nb_at_16_words", 32'(bus.nb_pack_available), 32'd1);
                if (i == 255) check("ovf_at_64_words", 32'(bus.overflow), 32'd0);
                if (i == 259) check("ovf_at_65_words", 32'(bus.overflow), 32'd1);
            end
            if (mode == 2 && i == ack_at) begin
                check("full_pushpop_count", 32'(dut.u_fifo.count_q), 32'd64);
                check("full_pushpop_ovf", 32'(bus.overflow), 32'd0);
                check("full_pushpop_head", bus.data_fifo, 32'h07060504);
            end
            if (mode == 2 && i == ack_at + 4) check("full_push_ovf", 32'(bus.overflow), 32'd1);
        end
        idle(2);
        bus.frame_valid = 1'b0;
        idle(4);
    endtask

    initial begin
        bus.new_addr    = 1'b0;
        bus.frame_valid = 1'b0;
        bus.line_valid  = 1'b0;
        bus.pixel_in    = '0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_data", bus.data_fifo, 32'd0);
        check("rst_nb", 32'(bus.nb_pack_available), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_short", 32'(bus.short_frame), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        nRST = 1'b1;
        idle(2);

        // full ramp frame with the store model popping on demand
        arm();
        check("arm_state", 32'(dut.state_q), 32'(ST_WAIT_SOF));
        pop_base = pop_cnt;
        auto_pop = 1'b1;
        frame(PW * PH, -1, -1, 0);
        idle(60);
        auto_pop = 1'b0;
        check("f1_words", 32'(pop_cnt - pop_base), 32'd512);
        check("f1_first", first_word, 32'h03020100);
        check("f1_errs", 32'(err_cnt), 32'd0);
        check("f1_ovf", 32'(bus.overflow), 32'd0);
        check("f1_short", 32'(bus.short_frame), 32'd0);
        check("f1_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("f1_empty", bus.data_fifo, 32'd0);

        // re-arm mid-frame: flush, then wait for the next frame start
        arm();
        frame(200, 40, -1, 0);
        check("mid_state", 32'(dut.state_q), 32'(ST_WAIT_SOF));
        check("mid_data", bus.data_fifo, 32'd0);
        check("mid_count", 32'(dut.u_fifo.count_q), 32'd0);
        pop_base = pop_cnt;
        auto_pop = 1'b1;
        frame(PW * PH, -1, -1, 0);
        idle(60);
        auto_pop = 1'b0;
        check("f2_words", 32'(pop_cnt - pop_base), 32'd512);
        check("f2_first", first_word, 32'h03020100);
        check("f2_errs", 32'(err_cnt), 32'd0);

        // no pops: FIFO fills and overflows
        arm();
        frame(PW * PH, -1, -1, 1);
        check("f3_count", 32'(dut.u_fifo.count_q), 32'd64);
        check("f3_ovf", 32'(bus.overflow), 32'd1);
        check("f3_head", bus.data_fifo, 32'h03020100);
        arm();
        check("f3_clr_data", bus.data_fifo, 32'd0);
        check("f3_clr_ovf", 32'(bus.overflow), 32'd0);
        check("f3_clr_count", 32'(dut.u_fifo.count_q), 32'd0);
        check("f3_clr_nb", 32'(bus.nb_pack_available), 32'd0);

        // push and pop together on a full FIFO
        frame(PW * PH, -1, 259, 2);
        check("f4_head", bus.data_fifo, 32'h07060504);
        check("f4_ovf", 32'(bus.overflow), 32'd1);
        arm();
        man_ack = 1'b1;
        idle(2);
        man_ack = 1'b0;
        check("ack_empty_data", bus.data_fifo, 32'd0);
        check("ack_empty_count", 32'(dut.u_fifo.count_q), 32'd0);

        // short frame: 1001 pixels -> 250 words, last pixel dropped
        arm();
        pop_base = pop_cnt;
        auto_pop = 1'b1;
        frame(1001, -1, -1, 0);
        idle(60);
        auto_pop = 1'b0;
        check("short_flag", 32'(bus.short_frame), 32'd1);
        check("short_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("short_popped", 32'(pop_cnt - pop_base), 32'd240);
        check("short_errs", 32'(err_cnt), 32'd0);
        check("short_count", 32'(dut.u_fifo.count_q), 32'd10);
        last_word = '0;
        for (int k = 0; k < 10; k++) begin
            man_ack   = 1'b1;
            last_word = bus.data_fifo;
            @(negedge clk);
        end
        man_ack = 1'b0;
        check("short_last", last_word, 32'hE7E6E5E4);
        check("short_drained", bus.data_fifo, 32'd0);

        // reset mid-capture
        arm();
        bus.frame_valid = 1'b1;
        idle(2);
        for (int i = 0; i < 20; i++) pix(8'(i));
        check("prerst_head", bus.data_fifo, 32'h03020100);
        check("prerst_count", 32'(dut.u_fifo.count_q), 32'd5);
        nRST = 1'b0;
        pix(8'd20);
        nRST = 1'b1;
        check("midrst_data", bus.data_fifo, 32'd0);
        check("midrst_count", 32'(dut.u_fifo.count_q), 32'd0);
        check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("midrst_short", 32'(bus.short_frame), 32'd0);
        for (int i = 21; i < 60; i++) pix(8'(i));
        check("postrst_data", bus.data_fifo, 32'd0);
        idle(2);
        bus.frame_valid = 1'b0;
        idle(4);
        bus.frame_valid = 1'b1;
        idle(2);
        for (int i = 0; i < 40; i++) pix(8'(i));
        check("unarmed_data", bus.data_fifo, 32'd0);
        check("unarmed_state", 32'(dut.state_q), 32'(ST_IDLE));
        idle(2);
        bus.frame_valid = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_in_pack.md
# video_in_pack

Upstream neighbour of the video input store stage: samples the 8-bit camera pixel stream, packs four consecutive pixels into one 32-bit word and buffers words in a synchronous FIFO. Exposes the show-ahead head word, a "pack available" flag and a read-acknowledge pop interface to the store stage. Armed once per frame by `new_addr`, so every stored image starts on a frame boundary.

## Interface
- `p_WIDTH`, 640, pixels per line (multiple of 4)
- `p_HEIGHT`, 480, lines per frame
- `NB_PACK_STORE`, 16, words per burst; `(p_WIDTH*p_HEIGHT/4) % NB_PACK_STORE == 0`
- `FIFO_DEPTH`, 64, words; power of 2, ≥ 2*NB_PACK_STORE
- `clk` in 1: single clock, all logic on posedge
- `nRST` in 1: synchronous, active-low reset
- `new_addr` in 1: one-cycle arm/flush pulse from the store stage
- `frame_valid` in 1: camera frame strobe
- `line_valid` in 1: camera line strobe
- `pixel_in` in 8: camera pixel, valid when `frame_valid & line_valid`
- `r_ack` in 1: pop head word (one word per asserted cycle)
- `data_fifo` out 32: head word, show-ahead; 0 when FIFO empty
- `nb_pack_available` out 1: FIFO count ≥ NB_PACK_STORE
- `overflow` out 1: sticky, a word was dropped on a full FIFO
- `short_frame` out 1: sticky, frame ended before p_WIDTH*p_HEIGHT pixels

## Operation
- States: IDLE (disarmed), WAIT_SOF (armed, waiting frame start), CAPTURE.
- IDLE → WAIT_SOF on `new_addr`. WAIT_SOF → CAPTURE on rising edge of `frame_valid` (registered previous value 0, current 1); a frame already in progress when armed is skipped.
- CAPTURE: each cycle with `frame_valid & line_valid` samples `pixel_in`; pixel k of a group goes to bits [8k+7:8k] (first pixel in [7:0]). On the 4th pixel, the word `{p3,p2,p1,p0}` is written into the FIFO at that edge.
- Pixel counter (20 bits) counts accepted pixels; when it reaches p_WIDTH*p_HEIGHT → IDLE. Pixels after that are ignored until re-armed.
- `frame_valid` falling in CAPTURE before the count completes: partial group discarded, `short_frame` ← 1, → IDLE.
- FIFO full on a write with no simultaneous pop: word dropped, `overflow` ← 1, capture continues. Full with simultaneous pop: write accepted.
- `r_ack` on an empty FIFO: ignored, count stays 0.
- `new_addr` in any state: FIFO emptied, packer and pixel counter cleared, `overflow`/`short_frame` cleared, → WAIT_SOF. A pixel in the same cycle is discarded.

## Timing
- Reset (nRST=0 at posedge): state IDLE, FIFO empty, counters 0, `data_fifo`=0, `nb_pack_available`=0, `overflow`=0, `short_frame`=0.
- Write latency: 4th pixel sampled at edge N; word becomes head on `data_fifo` and counts toward `nb_pack_available` after edge N, if the FIFO was empty.
- `data_fifo` and `nb_pack_available` are combinational from FIFO registers; no input-to-output combinational path.
- Pop: `r_ack` high at edge M advances the head; new head on `data_fifo` after M. The store stage samples `data_fifo` one cycle before asserting `r_ack`; the head must stay stable until popped.
- Simultaneous push and pop: count unchanged, both take effect.
- `nb_pack_available` drops in the cycle after the pop that brings the count below NB_PACK_STORE.

## Structure
- Package `video_in_pkg`: p_WIDTH, p_HEIGHT, NB_PACK_STORE defaults; pack-state enum; the pixel-count-per-frame constant. Shared with the store stage.
- Sub-module `video_in_fifo`: synchronous show-ahead FIFO (data, push, pop, full, empty, count). This block holds the FSM, packer and flags.

## Test plan
- Reset, then `new_addr` with frame_valid low, then a 640×480 ramp frame (pixel = index mod 256) with the store model popping on demand → 76800 words popped, first word 0x03020100, `nb_pack_available` rises exactly when count reaches 16, no flags.
- `new_addr` mid-frame → nothing is captured until the next frame_valid rise; first popped word equals the first 4 pixels of the next frame.
- No pops during a full frame → FIFO holds 64 words, `overflow`=1 after the 65th word, head still 0x03020100; `new_addr` clears the FIFO and the flag.
- frame_valid falls after 1001 pixels → 250 words in the FIFO, `short_frame`=1, state IDLE, the last partial pixel is not written.
- FIFO full with push and `r_ack` in the same cycle → count stays 64, no `overflow`; `r_ack` on empty → `data_fifo`=0, count 0.
- nRST low mid-capture for one cycle → all outputs return to reset values on that edge; pixels are ignored until the next `new_addr` and frame start.
